// File: rtl/cla_pkg.sv
// cla_pkg: shared constants, group generate/propagate type and lookahead helper
// for the pipelined carry-lookahead adder. Imported by cla_group4 and pipelined_cla_adder.
package cla_pkg;
   localparam int GROUP_W = 4;
   typedef struct packed {
      logic g;
      logic p;
   } gp_t;
   function automatic gp_t group_gp(input logic [3:0] g, input logic [3:0] p);
      gp_t r;
      r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      r.p = &p;
      return r;
   endfunction
endpackage

// File: rtl/cla_group4.sv
// cla_group4: combinational 4-bit carry-lookahead group.
// Ports: a, b   - 4-bit operands
//        cin    - carry into the group
//        s      - 4-bit sum
//        cout   - carry out of the group
//        g_grp  - group generate
//        p_grp  - group propagate
module cla_group4 import cla_pkg::*; (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout,
   output logic       g_grp,
   output logic       p_grp
);
   logic [3:0] g, p, c;
   gp_t gp;
   always_comb begin
      g = a & b;
      p = a ^ b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      gp = group_gp(g, p);
      s = p ^ c;
      cout = gp.g | (gp.p & cin);
      g_grp = gp.g;
      p_grp = gp.p;
   end
endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit adder/subtractor split into STAGES lookahead slices with
// a registered carry between slices and valid/ready backpressure per stage.
// Ports: clk, rst_n (async active-low)
//        in_valid/in_ready, a, b, c_in, sub  - operand handshake (sub: A-B-c_in)
//        out_valid/out_ready, sum, c_out     - result handshake (c_out=1 means no borrow in sub)
//        ovf                                 - signed overflow, present only with CLA_OVERFLOW_FLAG_EN
module pipelined_cla_adder import cla_pkg::*; #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
`ifdef CLA_OVERFLOW_FLAG_EN
   ,
   output logic             ovf
`endif
);
   localparam int SW = WIDTH / STAGES;
   localparam int NG = SW / GROUP_W;
   localparam int L  = STAGES - 1;
   logic [WIDTH-1:0] a_q [STAGES], a_d [STAGES], b_q [STAGES], b_d [STAGES];
   logic [WIDTH-1:0] sum_q [STAGES], sum_d [STAGES];
   logic [WIDTH-1:0] a_in [STAGES], b_in [STAGES], s_in [STAGES];
   logic [SW-1:0]    ss [STAGES];
   logic [STAGES-1:0] v_q, v_d, c_q, c_d, sub_q, sub_d, load, ci, sco, scm, sub_in;
   logic [STAGES:0]   vin;
   logic              rdy_q, rdy_d, nxt, en, c_eff;
   logic [WIDTH-1:0]  b_eff;
   assign b_eff = sub ? ~b : b;
   assign c_eff = sub ? ~c_in : c_in;
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
         assign a_in[k]   = a;
         assign b_in[k]   = b_eff;
         assign s_in[k]   = '0;
         assign sub_in[k] = sub;
         assign ci[k]     = c_eff;
      end else begin : g_next
         assign a_in[k]   = a_q[k-1];
         assign b_in[k]   = b_q[k-1];
         assign s_in[k]   = sum_q[k-1];
         assign sub_in[k] = sub_q[k-1];
         assign ci[k]     = c_q[k-1];
      end
      logic [NG:0]   gc;
      logic [NG-1:0] gg, gpp, gco;
      assign gc[0] = ci[k];
      for (genvar j = 0; j < NG; j++) begin : g_grp
         cla_group4 u_grp (
            .a     (a_in[k][k*SW + j*GROUP_W +: GROUP_W]),
            .b     (b_in[k][k*SW + j*GROUP_W +: GROUP_W]),
            .cin   (gc[j]),
            .s     (ss[k][j*GROUP_W +: GROUP_W]),
            .cout  (gco[j]),
            .g_grp (gg[j]),
            .p_grp (gpp[j])
         );
         // inter-group carry from group G/P keeps the slice carry path lookahead
         assign gc[j+1] = gg[j] | (gpp[j] & gc[j]);
      end
      assign sco[k] = gc[NG];
      // carry into the slice MSB, recovered from its sum bit
      assign scm[k] = a_in[k][k*SW + SW - 1] ^ b_in[k][k*SW + SW - 1] ^ ss[k][SW-1];
   end
   // a stage loads when empty or when its successor drains it this cycle
   always_comb begin
      nxt = out_ready;
      load = '0;
      for (int k = L; k >= 0; k--) begin
         load[k] = ~v_q[k] | nxt;
         nxt = load[k];
      end
   end
   assign in_ready = rdy_q & load[0];
   assign vin = {v_q, in_valid & in_ready};
   always_comb begin
      rdy_d = 1'b1;
      en = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         en = load[k] & vin[k];
         v_d[k] = load[k] ? vin[k] : v_q[k];
         a_d[k] = en ? a_in[k] : a_q[k];
         b_d[k] = en ? b_in[k] : b_q[k];
         sub_d[k] = en ? sub_in[k] : sub_q[k];
         c_d[k] = en ? sco[k] : c_q[k];
         sum_d[k] = en ? s_in[k] : sum_q[k];
         if (en) sum_d[k][k*SW +: SW] = ss[k];
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q <= 1'b0;
         v_q <= '0;
         c_q <= '0;
         sub_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            sum_q[k] <= '0;
         end
      end else begin
         rdy_q <= rdy_d;
         v_q <= v_d;
         c_q <= c_d;
         sub_q <= sub_d;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            sum_q[k] <= sum_d[k];
         end
      end
   end
   assign out_valid = v_q[L];
   assign sum = sum_q[L];
   assign c_out = c_q[L];
`ifdef CLA_OVERFLOW_FLAG_EN
   logic ovf_q, ovf_d;
   assign ovf_d = (load[L] & vin[L]) ? (scm[L] ^ sco[L]) : ovf_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovf_q <= 1'b0;
      else ovf_q <= ovf_d;
   end
   assign ovf = ovf_q;
`endif
endmodule
